// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, serial frame bit levels and the
// arbiter state encoding used by the transmit-side blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // Line levels of the framing bits; uart_tx uses the same constants.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        SEND   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: returns the first asserted request at or above ptr,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    grant,
    output logic               any_req
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    logic            found;

    // Scan NUM_REQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(i);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer between NUM_REQ byte producers.
// Requesters hold valid and data stable until their one-cycle req_ack.
// Toward uart_tx, tx_start is held with stable tx_data until busy rises
// (accepted) or START_TIMEOUT cycles elapse (byte dropped, timeout_err).
// All outputs are registered; arbitration happens only in IDLE.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ       = 4,
    parameter  int START_TIMEOUT = 16,
    localparam int ID_W          = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]               req_ack,
    output logic                             tx_start,
    output logic [UART_DATA_W-1:0]           tx_data,
    input  logic                             tx_busy,
    output logic                             frame_done,
    output logic [ID_W-1:0]                  done_id,
    output logic                             timeout_err,
    output logic [1:0]                       state_dbg
);

    localparam int TO_W = $clog2(START_TIMEOUT) + 1;

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]        active_id_q, active_id_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   tx_start_q, tx_start_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]     req_ack_q, req_ack_d;
    logic                   frame_done_q, frame_done_d;
    logic [ID_W-1:0]        done_id_q, done_id_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [ID_W-1:0]        grant;
    logic                   any_req;
    logic [UART_DATA_W-1:0] req_bytes [NUM_REQ];

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    // Unflatten the request bytes so the grant index selects directly.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_bytes[k] = req_data[k*UART_DATA_W +: UART_DATA_W];
        end
    end

    // Next-state logic for grant, launch handshake and frame tracking.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        active_id_d   = active_id_q;
        to_cnt_d      = to_cnt_q;
        tx_start_d    = tx_start_q;
        tx_data_d     = tx_data_q;
        done_id_d     = done_id_q;
        req_ack_d     = '0;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    tx_data_d   = req_bytes[grant];
                    active_id_d = grant;
                    req_ack_d   = NUM_REQ'(1) << grant;
                    tx_start_d  = 1'b1;
                    rr_ptr_d    = (grant == ID_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
                    to_cnt_d    = '0;
                    state_d     = LAUNCH;
                end else begin
                    tx_start_d = 1'b0;
                    tx_data_d  = '0;
                end
            end
            LAUNCH: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = SEND;
                end else if (to_cnt_q == TO_W'(START_TIMEOUT-1)) begin
                    tx_start_d    = 1'b0;
                    timeout_err_d = 1'b1;
                    done_id_d     = active_id_q;
                    state_d       = IDLE;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    frame_done_d = 1'b1;
                    done_id_d    = active_id_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops tx_start immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            active_id_q   <= '0;
            to_cnt_q      <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            req_ack_q     <= '0;
            frame_done_q  <= 1'b0;
            done_id_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            active_id_q   <= active_id_d;
            to_cnt_q      <= to_cnt_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            req_ack_q     <= req_ack_d;
            frame_done_q  <= frame_done_d;
            done_id_q     <= done_id_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign frame_done  = frame_done_q;
    assign done_id     = done_id_q;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a small behavioural uart_tx (optionally a
// stub that never raises busy) and a serial line monitor.
module tb_uart_tx_arbiter;

    localparam int CPB = 4;  // clocks per serial bit in the uart_tx model

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        frame_done;
    logic [1:0]  done_id;
    logic        timeout_err;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .START_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .frame_done  (frame_done),
        .done_id     (done_id),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    // ---------------- uart_tx model ----------------
    logic       stub_mode = 1'b0;
    logic       tx_out;
    logic [8:0] sh;
    int         bits_left;
    int         div;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_busy <= 1'b0; tx_out <= 1'b1; sh <= '0; bits_left <= 0; div <= 0;
        end else if (stub_mode) begin
            tx_busy <= 1'b0; tx_out <= 1'b1;
        end else if (!tx_busy) begin
            if (tx_start) begin
                tx_busy <= 1'b1; tx_out <= 1'b0; sh <= {1'b1, tx_data};
                bits_left <= 9; div <= 0;
            end
        end else if (div == CPB-1) begin
            div <= 0;
            if (bits_left == 0) tx_busy <= 1'b0;
            else begin
                tx_out <= sh[0]; sh <= sh >> 1; bits_left <= bits_left - 1;
            end
        end else begin
            div <= div + 1;
        end
    end

    // ---------------- serial monitor ----------------
    logic       mon_active;
    int         mon_div, mon_idx;
    int         mon_cnt = 0;
    logic [9:0] mon_bits, mon_frame = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mon_active <= 1'b0; mon_div <= 0; mon_idx <= 0; mon_bits <= '0;
        end else if (!mon_active) begin
            if (tx_out == 1'b0) begin
                mon_active <= 1'b1; mon_div <= 1; mon_idx <= 0;
            end
        end else begin
            mon_div <= (mon_div + 1) % CPB;
            if (mon_div == 1) begin
                mon_bits[mon_idx] <= tx_out;
                mon_idx <= mon_idx + 1;
                if (mon_idx == 9) begin
                    mon_active <= 1'b0;
                    mon_frame  <= {tx_out, mon_bits[8:0]};
                    mon_cnt    <= mon_cnt + 1;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ack(output logic [3:0] ack);
        ack = '0;
        for (int n = 0; n < 200 && ack == 4'b0; n++) begin
            @(negedge clk);
            if (req_ack != 4'b0) ack = req_ack;
        end
        if (ack == 4'b0) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no req_ack expected one within 200 cycles");
        end
    endtask

    task automatic wait_done(output int acks_seen);
        bit got = 1'b0;
        acks_seen = 0;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
            if (req_ack != 4'b0) acks_seen++;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no frame_done expected one within 400 cycles");
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] add;     // request bits raised before this grant
        int         exp_id;  // requester expected to be granted
        bit         clr;     // drop all pending requests after the frame
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] data_tab[4];
    logic [3:0] pend;
    logic [3:0] ack;
    int         acks_seen;
    int         cnt0;
    int         n_start;
    int         fd_seen;
    int         to_seen;

    // ---------------- stimulus ----------------
    initial begin
        data_tab[0] = 8'h10; data_tab[1] = 8'h21; data_tab[2] = 8'h32; data_tab[3] = 8'h43;
        // round robin from rr_ptr=0, then only 0 and 3 re-raised
        vecs[0]  = '{4'b1111, 0, 1'b0};
        vecs[1]  = '{4'b0000, 1, 1'b0};
        vecs[2]  = '{4'b0000, 2, 1'b0};
        vecs[3]  = '{4'b0000, 3, 1'b0};
        vecs[4]  = '{4'b1001, 0, 1'b0};
        vecs[5]  = '{4'b0000, 3, 1'b0};
        // grant 2 leaves rr_ptr=3; then 0 and 3 held continuously
        vecs[6]  = '{4'b0100, 2, 1'b0};
        vecs[7]  = '{4'b1001, 3, 1'b0};
        vecs[8]  = '{4'b1001, 0, 1'b0};
        vecs[9]  = '{4'b1001, 3, 1'b0};
        vecs[10] = '{4'b1001, 0, 1'b0};
        vecs[11] = '{4'b1001, 3, 1'b0};

        req_data = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
        do_reset();

        // reset values
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_req_ack", req_ack, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_state", state_dbg, 0);

        // single request from requester 2 carrying A5
        req_data[23:16] = 8'hA5;
        cnt0 = mon_cnt;
        req_valid = 4'b0100;
        wait_ack(ack);
        chk("t1_ack", ack, 4'b0100);
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_tx_start", tx_start, 1);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("t1_ack_one_cycle", req_ack, 0);
        wait_done(acks_seen);
        chk("t1_done_id", done_id, 2);
        chk("t1_frame_bits", mon_frame, {1'b1, 8'hA5, 1'b0});
        chk("t1_frame_count", mon_cnt - cnt0, 1);
        @(negedge clk);
        chk("t1_done_one_cycle", frame_done, 0);
        req_data[23:16] = data_tab[2];

        // table-driven round robin and wrap fairness
        do_reset();
        pend = '0;
        for (int i = 0; i < 12; i++) begin
            pend = pend | vecs[i].add;
            req_valid = pend;
            wait_ack(ack);
            chk($sformatf("rr_ack_%0d", i), ack, 4'b0001 << vecs[i].exp_id);
            chk($sformatf("rr_data_%0d", i), tx_data, data_tab[vecs[i].exp_id]);
            pend = pend & ~ack;
            req_valid = pend;
            wait_done(acks_seen);
            chk($sformatf("rr_done_id_%0d", i), done_id, vecs[i].exp_id);
            if (vecs[i].clr || i == 11) begin
                pend = '0;
                req_valid = '0;
            end
        end
        // rr_ptr is now 0 (last grant was 3)

        // start timeout with a stub that never raises busy
        stub_mode = 1'b1;
        req_valid = 4'b0010;
        wait_ack(ack);
        chk("t4_ack", ack, 4'b0010);
        req_valid = 4'b0000;
        n_start = tx_start ? 1 : 0;
        fd_seen = 0; to_seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (frame_done) fd_seen++;
            if (!tx_start) break;
            n_start++;
        end
        chk("t4_start_cycles", n_start, 16);
        chk("t4_timeout_err", timeout_err, 1);
        chk("t4_done_id", done_id, 1);
        @(negedge clk);
        if (frame_done) fd_seen++;
        chk("t4_timeout_one_cycle", timeout_err, 0);
        chk("t4_no_frame_done", fd_seen, 0);
        chk("t4_state_idle", state_dbg, 0);
        stub_mode = 1'b0;
        @(negedge clk);

        // late request during SEND; rr_ptr=2 so requester 0 wins, then 2
        req_valid = 4'b0001;
        wait_ack(ack);
        chk("t5_ack0", ack, 4'b0001);
        req_valid = 4'b0000;
        for (int n = 0; n < 50 && state_dbg != 2'd2; n++) @(negedge clk);
        chk("t5_in_send", state_dbg, 2);
        req_valid = 4'b0100;
        wait_done(acks_seen);
        chk("t5_no_ack_in_send", acks_seen, 0);
        chk("t5_done_id0", done_id, 0);
        @(negedge clk);
        chk("t5_ack2_next_cycle", req_ack, 4'b0100);
        req_valid = 4'b0000;
        wait_done(acks_seen);
        chk("t5_done_id2", done_id, 2);
        @(negedge clk);

        // reset during data bit 4 of a frame from requester 0
        req_valid = 4'b0001;
        wait_ack(ack);
        chk("t6_ack0", ack, 4'b0001);
        req_valid = 4'b0000;
        for (int n = 0; n < 200 && mon_idx != 5; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_rst_tx_start", tx_start, 0);
        chk("t6_rst_req_ack", req_ack, 0);
        chk("t6_rst_frame_done", frame_done, 0);
        chk("t6_rst_tx_data", tx_data, 0);
        chk("t6_rst_state", state_dbg, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cnt0 = mon_cnt;
        req_valid = 4'b0001;
        wait_ack(ack);
        chk("t6_post_ack", ack, 4'b0001);
        req_valid = 4'b0000;
        wait_done(acks_seen);
        chk("t6_post_done_id", done_id, 0);
        chk("t6_post_frame_bits", mon_frame, {1'b1, 8'h10, 1'b0});
        chk("t6_post_frame_count", mon_cnt - cnt0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
